fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first byte address fetched after reset.
REQ-002 SHALL have parameter DEPTH, default 4: prefetch queue entries; power of two, 2..16.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-005 SHALL have port imem_addr  output  32: byte address driven to the combinational-read instruction memory.
REQ-006 SHALL have port imem_inst  input  32: instruction word returned by memory in the same cycle as imem_addr.
REQ-007 SHALL have port redirect_valid  input  1: branch/jump redirect request from the execute stage.
REQ-008 SHALL have port redirect_pc  input  32: redirect target byte address.
REQ-009 SHALL have port out_valid  output  1: out_inst/out_pc hold a valid fetched instruction.
REQ-010 SHALL have port out_inst  output  32: instruction at the queue head.
REQ-011 SHALL have port out_pc  output  32: byte address of out_inst.
REQ-012 SHALL have port out_ready  input  1: decode accepts the head entry this cycle.

Function
REQ-013 SHALL drive imem_addr = {fetch_pc[31:2], 2'b00} combinationally from the internal fetch_pc register.
REQ-014 SHALL push {fetch_pc, imem_inst} into the queue and advance fetch_pc by 4 in a cycle when redirect_valid=0 and (count<DEPTH or a pop occurs that cycle).
REQ-015 SHALL pop the head entry when out_valid=1 and out_ready=1; out_valid SHALL equal (count!=0).
REQ-016 SHALL, on simultaneous push and pop, keep count unchanged, including at count=DEPTH.
REQ-017 SHALL hold fetch_pc and the queue unchanged when full and not popping; imem_addr stays at the stalled fetch_pc.
REQ-018 SHALL, when redirect_valid=1, flush every queue entry (count<=0, pointers equal), ignore any push or pop that cycle, and load fetch_pc <= {redirect_pc[31:2], 2'b00}.
REQ-019 SHALL give redirect priority over push, pop and stall; out_valid SHALL be 0 in the cycle after a redirect.
REQ-020 SHALL have a latency of one cycle: an instruction fetched at edge N is visible at out_* after edge N.
REQ-021 SHALL wrap fetch_pc modulo 2^32 (32'hFFFF_FFFC + 4 = 32'h0000_0000) and wrap queue pointers modulo DEPTH.
REQ-022 SHALL ignore out_ready when out_valid=0.

Reset
REQ-023 SHALL, while rst=1, asynchronously set fetch_pc=RESET_PC, count=0, read/write pointers=0 and out_valid=0.
REQ-024 SHALL drive out_inst and out_pc to 0 while out_valid=0.
REQ-025 SHALL abandon any in-flight fetch on a mid-operation reset; the first push after release is at RESET_PC.

Configuration
REQ-026 SHALL support macro FETCH_BYPASS_EN.
REQ-027 With FETCH_BYPASS_EN defined: when count=0 and redirect_valid=0, out_valid=1, out_inst=imem_inst and out_pc=fetch_pc combinationally; if out_ready=1 the word is consumed without being queued and fetch_pc still advances by 4.
REQ-028 Without FETCH_BYPASS_EN: outputs SHALL come only from the queue (REQ-020 latency).

Structure
REQ-029 SHALL take XLEN=32, ILEN=32 and NOP_INST=32'h0000_0013 from shared package riscv_pkg.
REQ-030 SHALL instantiate one sub-module, fetch_fifo: a synchronous FIFO of DEPTH x 64 bits with push, pop, flush and count.

Verification
REQ-031 Reset release with RESET_PC=0 and out_ready=1 -> out_pc sequence 0,4,8,... one per cycle; first valid one cycle after release.
REQ-032 out_ready=0 for 10 cycles, DEPTH=4 -> count saturates at 4, imem_addr frozen at 0x10; out_ready=1 then resumes at 0x10 with no skip or duplicate.
REQ-033 redirect_valid=1, redirect_pc=0x103 with the queue full -> next-cycle out_valid=0, then out_pc=0x100.
REQ-034 Redirect asserted in the same cycle as out_ready=1 at count=4 -> no pop is recorded; only 0x100-stream entries are observed afterwards.
REQ-035 redirect_pc=0xFFFF_FFFC -> out_pc sequence 0xFFFF_FFFC, then 0x0000_0000.
REQ-036 FETCH_BYPASS_EN defined, reset release, out_ready=1 -> out_valid=1 in the first cycle after release with out_pc=RESET_PC and count staying 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V widths and constants used by the fetch path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;
    localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;

    // Clear the two low address bits so every fetch address is word aligned.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH x WIDTH FIFO holding prefetched {pc, inst} pairs.
// Latency: a word pushed at edge N is at head_dat_o after edge N.
// Backpressure: none internally; the caller must not push when full unless
// it pops in the same cycle. flush_i overrides push and pop.
//
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   push_i/push_dat_i  write one entry at the tail
//   pop_i           drop the head entry
//   flush_i         discard all entries, pointers back to 0
//   head_dat_o      current head entry (undefined when empty)
//   count_o         number of valid entries, 0..DEPTH
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_dat_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [WIDTH-1:0]         head_dat_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // DEPTH is a power of two, so pointer overflow wraps modulo DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
            unique case ({push_i, pop_i})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch with a DEPTH-entry prefetch queue in front of decode.
// Latency: one cycle from fetch to out_* (zero with FETCH_BYPASS_EN and an empty queue).
// Backpressure: out_ready=0 fills the queue, then fetch_pc and imem_addr stall.
//
// Optional feature macro: FETCH_BYPASS_EN (empty-queue bypass of imem_inst to out_*).
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   imem_addr / imem_inst            combinational-read instruction memory
//   redirect_valid / redirect_pc     flush and restart fetch at a new address
//   out_valid / out_inst / out_pc    head instruction towards decode
//   out_ready                        decode accepts the head this cycle
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned     DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_addr,
    input  logic [ILEN-1:0] imem_inst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    output logic [ILEN-1:0] out_inst,
    output logic [XLEN-1:0] out_pc,
    input  logic            out_ready
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [XLEN-1:0]      fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]        count;
    logic [XLEN+ILEN-1:0] head_dat;
    logic                 queue_vld;
    logic                 full;
    logic                 bypass;
    logic                 bypass_take;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 advance;

    assign queue_vld = (count != '0);
    assign full      = (count == FULL_CNT);

`ifdef FETCH_BYPASS_EN
    // Empty queue: present the memory word directly to decode.
    assign bypass = !queue_vld && !redirect_valid;
`else
    assign bypass = 1'b0;
`endif

    assign bypass_take = bypass && out_ready;

    // Redirect wins over everything: no pop, no push, fetch_pc reloads.
    assign fifo_pop  = queue_vld && out_ready && !redirect_valid;
    assign advance   = !redirect_valid && (!full || fifo_pop);
    // A bypassed word that decode takes is consumed without entering the queue.
    assign fifo_push = advance && !bypass_take;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = word_align(redirect_pc);
        end else if (advance) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    assign imem_addr = word_align(fetch_pc_q);

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN + ILEN)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (fifo_push),
        .push_dat_i ({fetch_pc_q, imem_inst}),
        .pop_i      (fifo_pop),
        .flush_i    (redirect_valid),
        .head_dat_o (head_dat),
        .count_o    (count)
    );

    // Outputs read as zero whenever nothing valid is presented.
    always_comb begin
        out_valid = 1'b0;
        out_inst  = '0;
        out_pc    = '0;
        if (bypass) begin
            out_valid = 1'b1;
            out_inst  = imem_inst;
            out_pc    = fetch_pc_q;
        end else if (queue_vld) begin
            out_valid = 1'b1;
            out_inst  = head_dat[ILEN-1:0];
            out_pc    = head_dat[XLEN+ILEN-1:ILEN];
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_ready;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    // Instruction memory model: a distinct word per address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ~a ^ 32'h0F0F_5A00;
    endfunction

    assign imem_inst = mem_word(imem_addr);

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_inst      (imem_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_ready      (out_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Expected pc stream from base, wrapping modulo 2^32.
    task automatic load_stream(input logic [31:0] base);
        logic [31:0] pc;
        exp_q.delete();
        pc = base;
        for (int i = 0; i < 40; i++) begin
            exp_q.push_back(pc);
            pc = pc + 32'd4;
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted head is compared against the expected stream.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", out_pc, 32'hDEAD_DEAD);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_pc", out_pc, e);
                    check("sb_inst", out_inst, mem_word(e));
                end
            end else if (!out_valid) begin
                check("idle_pc_zero", out_pc, 32'h0);
                check("idle_inst_zero", out_inst, 32'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        exp_q.delete();

        // Reset state.
        step(3);
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check("rst_imem_addr", imem_addr, 32'h0);

        // Release with out_ready=1: stream 0,4,8,... one per cycle.
        load_stream(32'h0);
        rst = 1'b0;
        #1;
`ifdef FETCH_BYPASS_EN
        check("release_valid", {31'b0, out_valid}, 32'h1);
`else
        check("release_valid", {31'b0, out_valid}, 32'h0);
`endif
        step(1);
        check("first_valid", {31'b0, out_valid}, 32'h1);
`ifndef FETCH_BYPASS_EN
        check("first_pc", out_pc, 32'h0);
`endif
        step(8);

        // Mid-operation reset, then stall with out_ready=0.
        out_ready = 1'b0;
        rst       = 1'b1;
        #1;
        check("midrst_valid", {31'b0, out_valid}, 32'h0);
        check("midrst_addr", imem_addr, 32'h0);
        step(2);
        load_stream(32'h0);
        rst = 1'b0;
        step(10);
        check("stall_addr", imem_addr, 32'h10);
        check("stall_valid", {31'b0, out_valid}, 32'h1);
        check("stall_head", out_pc, 32'h0);
        step(1);
        check("stall_addr_frozen", imem_addr, 32'h10);
        out_ready = 1'b1;
        step(12);

        // Fill the queue, then redirect while decode is ready.
        out_ready = 1'b0;
        step(6);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        out_ready      = 1'b1;
        load_stream(32'h100);
        step(1);
        redirect_valid = 1'b0;
`ifndef FETCH_BYPASS_EN
        check("redir_valid_low", {31'b0, out_valid}, 32'h0);
`endif
        check("redir_addr", imem_addr, 32'h100);
        step(1);
        check("redir_first_pc", out_pc, 32'h100);
        step(6);

        // Redirect to the top of the address space: pc wraps to 0.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        load_stream(32'hFFFF_FFFC);
        step(1);
        redirect_valid = 1'b0;
        step(1);
        check("wrap_pc0", out_pc, 32'hFFFF_FFFC);
        step(1);
        check("wrap_pc1", out_pc, 32'h0000_0000);
        step(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
